cic_rate_ctrl: RTL and testbench
================================

Name: cic_rate_ctrl

Overview:
Rate and reconfiguration controller for the CIC decimator. Generates the decimated-rate strobe that clocks the filter's comb/output section. Applies oversampling-ratio (os_sel) changes only on a decimation boundary, then clears the filter and masks its start-up transient before declaring output valid. Sits between the register/config interface and cic_filter.

Parameters:
- OSW, 3: width of os_sel.
- MAX_OS, 7: largest legal os_sel. Requests above it are clamped.
- DEF_OS, 1: os_sel_o value after reset.
- CLR_CYCLES, 4: clk cycles cic_clr is held high per clear.
- SETTLE_SAMPLES, 4: decimated samples masked after a clear (equal to the number of CIC stages).

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: run enable (level).
- cfg_req, in, 1: reconfiguration request; level, held until cfg_ack.
- cfg_os_sel, in, OSW: requested decimation exponent (ratio = 2^os).
- cfg_ack, out, 1: one-cycle pulse when the request has been applied.
- os_sel_o, out, OSW: active os_sel driven to cic_filter.
- cic_clr, out, 1: synchronous clear to cic_filter integrators/combs.
- dec_strobe, out, 1: one-clk pulse per decimated sample (clk_div).
- out_valid, out, 1: cic_filter data_out is trustworthy on this strobe.
- busy, out, 1: high in WAIT_BND, CLEAR or SETTLE.
- stat_samples, out, 16: valid-sample count (see Optional Feature).
- stat_reconfig, out, 8: applied-reconfiguration count (see Optional Feature).

Behaviour:
- Reset state and outputs:
  - state=IDLE, os_sel_o=DEF_OS, phase counter=0.
  - cic_clr, dec_strobe, out_valid, cfg_ack, busy all 0.
  - stat counters 0.
- Reset asserted mid-operation aborts everything and returns to these values immediately (asynchronous).
- Phase counter: width MAX_OS bits, terminal value T=2^os_sel_o-1, wraps T->0.
  - dec_strobe is registered: high in the cycle after the counter equals T.
  - os_sel_o=0: dec_strobe high every cycle while counting.
  - Counter runs in RUN, WAIT_BND and SETTLE; held at 0 in IDLE and CLEAR.
- Clamp rule: os_new = min(cfg_os_sel, MAX_OS).
- IDLE:
  - No strobes.
  - cfg_req: os_sel_o<=os_new, cfg_ack pulses the next cycle.
  - enable=1 -> CLEAR.
- CLEAR:
  - cic_clr=1 for exactly CLR_CYCLES cycles, then -> SETTLE with counter=0.
- SETTLE:
  - Strobes are issued, out_valid=0.
  - After SETTLE_SAMPLES strobes -> RUN.
  - The first strobe in RUN is the first one with out_valid=1.
- RUN:
  - out_valid = dec_strobe.
  - cfg_req with os_new == os_sel_o: cfg_ack next cycle, no disturbance, count not incremented.
  - cfg_req with a different os_new -> WAIT_BND.
- WAIT_BND:
  - Strobes continue at the old rate, out_valid still follows them.
  - When counter == T (old), take the following actions:
    - the final old-rate strobe is still issued next cycle;
    - os_sel_o<=os_new, counter<=0;
    - cfg_ack pulses next cycle;
    - -> CLEAR.
- cfg_req during CLEAR/SETTLE: not acked. Because cfg_req is a level, it is serviced on return to RUN.
- cfg_os_sel is sampled when the request is applied, not when it is first raised.
- enable=0 in any state:
  - -> IDLE next cycle; all strobes, cic_clr and out_valid 0.
  - A pending request is not acked (it is serviced in IDLE if still held).
- Simultaneous enable rise and cfg_req in IDLE: the config is applied first (same cycle), then CLEAR runs with the new os.

Optional Feature:
- Macro: CIC_RATE_CTRL_STAT_EN.
- Defined:
  - stat_samples increments on every out_valid pulse, saturating at 0xFFFF.
  - stat_reconfig increments on every cfg_ack that changed os_sel_o, saturating at 0xFF.
  - Both cleared only by reset.
- Undefined: both ports tied to 0, no counter logic.

Test Plan:
1. Reset, DEF_OS=1, enable=1 -> cic_clr high 4 cycles; strobes every 2 clks; out_valid first on the 5th strobe; os_sel_o=1.
2. In RUN at os=1, cfg_req os=3 -> remaining old-rate strobes, ack at boundary, cic_clr 4 cycles, strobes every 8 clks, out_valid after 4 masked strobes.
3. cfg_req os=0 -> after clear, dec_strobe every cycle; 4 masked, then out_valid continuous.
4. cfg_req equal to current os in RUN -> cfg_ack 1 cycle later; no cic_clr; strobe spacing unchanged; stat_reconfig unchanged.
5. enable dropped during SETTLE -> next cycle dec_strobe/out_valid/busy=0; re-enable -> full 4-cycle clear plus 4 masked samples.
6. MAX_OS=5, cfg_os_sel=7 -> os_sel_o=5, strobe period 32; with CIC_RATE_CTRL_STAT_EN, stat_reconfig increments by 1 and stat_samples counts only valid strobes.

Source files
------------

// File: rtl/cic_rate_ctrl_if.sv
// ----------------------------------------------------------------------------
// cic_rate_ctrl_if
// Configuration / rate-control bundle between the register block (master) and
// cic_rate_ctrl (slave).
//   enable        : run enable (level)
//   cfg_req       : reconfiguration request, level held until cfg_ack
//   cfg_os_sel    : requested decimation exponent (ratio = 2^os)
//   cfg_ack       : one-cycle pulse when the request has been applied
//   os_sel_o      : active os_sel driven to cic_filter
//   cic_clr       : synchronous clear to cic_filter integrators/combs
//   dec_strobe    : one-clk pulse per decimated sample
//   out_valid     : cic_filter data_out is trustworthy on this strobe
//   busy          : boundary wait, clear or settle in progress
//   stat_samples  : valid-sample count
//   stat_reconfig : applied-reconfiguration count
// ----------------------------------------------------------------------------
interface cic_rate_ctrl_if #(
   parameter int unsigned OSW = 3
);
   logic            enable;
   logic            cfg_req;
   logic [OSW-1:0]  cfg_os_sel;
   logic            cfg_ack;
   logic [OSW-1:0]  os_sel_o;
   logic            cic_clr;
   logic            dec_strobe;
   logic            out_valid;
   logic            busy;
   logic [15:0]     stat_samples;
   logic [7:0]      stat_reconfig;

   modport master (
      output enable, cfg_req, cfg_os_sel,
      input  cfg_ack, os_sel_o, cic_clr, dec_strobe, out_valid, busy,
             stat_samples, stat_reconfig
   );

   modport slave (
      input  enable, cfg_req, cfg_os_sel,
      output cfg_ack, os_sel_o, cic_clr, dec_strobe, out_valid, busy,
             stat_samples, stat_reconfig
   );
endinterface

// File: rtl/cic_rate_ctrl.sv
// ----------------------------------------------------------------------------
// cic_rate_ctrl
// Rate and reconfiguration controller for the CIC decimator. Produces the
// decimated-rate strobe, applies os_sel changes only on a decimation boundary,
// clears the filter and masks its start-up transient before flagging valid
// output.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : cic_rate_ctrl_if.slave (enable, cfg_req/cfg_os_sel/cfg_ack,
//             os_sel_o, cic_clr, dec_strobe, out_valid, busy, stat_*)
// Optional: define CIC_RATE_CTRL_STAT_EN to build the saturating
//   stat_samples / stat_reconfig counters; otherwise both read as 0.
// ----------------------------------------------------------------------------
module cic_rate_ctrl #(
   parameter int unsigned OSW            = 3,
   parameter int unsigned MAX_OS         = 7,
   parameter int unsigned DEF_OS         = 1,
   parameter int unsigned CLR_CYCLES     = 4,
   parameter int unsigned SETTLE_SAMPLES = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   cic_rate_ctrl_if.slave  bus
);

   localparam int unsigned PW = MAX_OS;
   localparam int unsigned CW = $clog2(CLR_CYCLES + 1);
   localparam int unsigned SW = $clog2(SETTLE_SAMPLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SETTLE,
      ST_RUN,
      ST_WAIT_BND
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
   logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
   logic [OSW-1:0]  os_q, os_d;
   logic            ack_q, ack_d;
   logic            clr_q, clr_d;
   logic            strobe_q, strobe_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;

   logic [PW-1:0]   term_c;
   logic [OSW-1:0]  os_new_c;
   logic            counting_c;
   logic            next_counting_c;
   logic            at_term_c;
   logic            req_new_c;
   logic            apply_c;

   // Terminal phase 2^os-1 as a mask of os low ones; clamp of the request.
   always_comb begin
      term_c     = ~({PW{1'b1}} << os_q);
      os_new_c   = (bus.cfg_os_sel > OSW'(MAX_OS)) ? OSW'(MAX_OS) : bus.cfg_os_sel;
      counting_c = state_q inside {ST_SETTLE, ST_RUN, ST_WAIT_BND};
      at_term_c  = counting_c && (phase_q == term_c);
      // cfg_req is still high during the ack cycle; do not service it twice.
      req_new_c  = bus.cfg_req && !ack_q;
   end

   // State register and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         clr_cnt_q    <= '0;
         settle_cnt_q <= '0;
         os_q         <= OSW'(DEF_OS);
         ack_q        <= 1'b0;
         clr_q        <= 1'b0;
         strobe_q     <= 1'b0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         clr_cnt_q    <= clr_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         os_q         <= os_d;
         ack_q        <= ack_d;
         clr_q        <= clr_d;
         strobe_q     <= strobe_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      apply_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Config is applied even while enabling, so CLEAR runs at the new os.
            apply_c = req_new_c;
            if (bus.enable) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (clr_cnt_q == CW'(CLR_CYCLES - 1)) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (at_term_c && (settle_cnt_q == SW'(SETTLE_SAMPLES - 1))) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (req_new_c) begin
               if (os_new_c == os_q) apply_c = 1'b1;
               else                  state_d = ST_WAIT_BND;
            end
         end
         ST_WAIT_BND: begin
            if (!bus.cfg_req) begin
               state_d = ST_RUN;
            end else if (at_term_c) begin
               apply_c = 1'b1;
               state_d = ST_CLEAR;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Dropping enable aborts any state; a pending request waits for IDLE.
      if (!bus.enable && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         apply_c = 1'b0;
      end

      next_counting_c = state_d inside {ST_SETTLE, ST_RUN, ST_WAIT_BND};

      phase_d      = (counting_c && next_counting_c) ?
                     (at_term_c ? '0 : phase_q + PW'(1)) : '0;
      clr_cnt_d    = ((state_q == ST_CLEAR) && (state_d == ST_CLEAR)) ?
                     clr_cnt_q + CW'(1) : '0;
      settle_cnt_d = ((state_q == ST_SETTLE) && (state_d == ST_SETTLE)) ?
                     settle_cnt_q + SW'(at_term_c) : '0;
      os_d         = apply_c ? os_new_c : os_q;
      ack_d        = apply_c;
      clr_d        = (state_d == ST_CLEAR);
      // The boundary strobe out of WAIT_BND is still an old-rate valid sample.
      strobe_d     = bus.enable && at_term_c;
      valid_d      = bus.enable && at_term_c && (state_q inside {ST_RUN, ST_WAIT_BND});
      busy_d       = state_d inside {ST_WAIT_BND, ST_CLEAR, ST_SETTLE};
   end

   assign bus.cfg_ack    = ack_q;
   assign bus.os_sel_o   = os_q;
   assign bus.cic_clr    = clr_q;
   assign bus.dec_strobe = strobe_q;
   assign bus.out_valid  = valid_q;
   assign bus.busy       = busy_q;

`ifdef CIC_RATE_CTRL_STAT_EN
   logic [15:0] samples_q;
   logic [7:0]  reconf_q;

   // Saturating statistics, updated together with the pulse they count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         samples_q <= '0;
         reconf_q  <= '0;
      end else begin
         if (valid_d && (samples_q != 16'hFFFF)) samples_q <= samples_q + 16'd1;
         if (apply_c && (os_new_c != os_q) && (reconf_q != 8'hFF)) reconf_q <= reconf_q + 8'd1;
      end
   end

   assign bus.stat_samples  = samples_q;
   assign bus.stat_reconfig = reconf_q;
`else
   assign bus.stat_samples  = '0;
   assign bus.stat_reconfig = '0;
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cic_rate_ctrl
// Directed scenarios followed by randomized enable/request traffic, compared
// every cycle against a behavioural model of the rate controller.
// ----------------------------------------------------------------------------
module tb_cic_rate_ctrl;

   localparam int MAX_OS = 5;
   localparam int DEF_OS = 1;
   localparam int CLR_N  = 4;
   localparam int SET_N  = 4;

   localparam int M_IDLE   = 0;
   localparam int M_CLEAR  = 1;
   localparam int M_SETTLE = 2;
   localparam int M_RUN    = 3;
   localparam int M_WAIT   = 4;

   logic clk;
   logic reset_n;

   cic_rate_ctrl_if #(.OSW(3)) bus_if ();

   cic_rate_ctrl #(.OSW(3), .MAX_OS(MAX_OS), .DEF_OS(DEF_OS),
                   .CLR_CYCLES(CLR_N), .SETTLE_SAMPLES(SET_N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_mode, m_ph, m_os, m_clr, m_set, m_samples, m_reconf;
   bit m_ack, m_strobe, m_valid, m_cclr, m_busy;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_mode = M_IDLE; m_ph = 0; m_os = DEF_OS; m_clr = 0; m_set = 0;
         m_ack = 0; m_strobe = 0; m_valid = 0; m_cclr = 0; m_busy = 0;
         m_samples = 0; m_reconf = 0;
      end else begin : step
         int  period, osn, nm;
         bit  counting, hit, fresh, apply, en;
         en       = bus_if.enable;
         period   = 1 << m_os;
         counting = (m_mode == M_SETTLE) || (m_mode == M_RUN) || (m_mode == M_WAIT);
         hit      = counting && (m_ph == period - 1);
         fresh    = bus_if.cfg_req && !m_ack;
         osn      = (int'(bus_if.cfg_os_sel) > MAX_OS) ? MAX_OS : int'(bus_if.cfg_os_sel);
         apply    = 0;
         nm       = m_mode;
         if (!en) begin
            if (m_mode == M_IDLE && fresh) apply = 1;
            nm = M_IDLE;
         end else if (m_mode == M_IDLE) begin
            apply = fresh;
            nm    = M_CLEAR;
         end else if (m_mode == M_CLEAR) begin
            if (m_clr == CLR_N - 1) nm = M_SETTLE;
         end else if (m_mode == M_SETTLE) begin
            if (hit && m_set == SET_N - 1) nm = M_RUN;
         end else if (m_mode == M_RUN) begin
            if (fresh) begin
               if (osn == m_os) apply = 1;
               else             nm = M_WAIT;
            end
         end else begin
            if (!bus_if.cfg_req) nm = M_RUN;
            else if (hit) begin apply = 1; nm = M_CLEAR; end
         end

         m_strobe = en && hit;
         m_valid  = en && hit && (m_mode == M_RUN || m_mode == M_WAIT);
         m_ack    = apply;
         m_cclr   = (nm == M_CLEAR);
         m_busy   = (nm == M_CLEAR) || (nm == M_SETTLE) || (nm == M_WAIT);
         if (m_valid && m_samples < 65535) m_samples++;
         if (apply && osn != m_os && m_reconf < 255) m_reconf++;

         if (counting && (nm == M_SETTLE || nm == M_RUN || nm == M_WAIT))
            m_ph = (m_ph + 1) % period;
         else
            m_ph = 0;
         m_clr = (m_mode == M_CLEAR && nm == M_CLEAR) ? m_clr + 1 : 0;
         m_set = (m_mode == M_SETTLE && nm == M_SETTLE) ? m_set + int'(hit) : 0;
         if (apply) m_os = osn;
         m_mode = nm;
      end
   end

   // ---------------- per-cycle compare and measurements ----------------
   int cyc = 0, last_strobe = 0, period_meas = 0;
   int clr_run = 0, clr_len = 0, clr_rises = 0, masked = 0, masked_meas = -1;
   int valid_cnt = 0;
   bit seen_valid = 0, prev_clr = 0;

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         clr_run = 0; valid_cnt = 0; prev_clr = 0;
      end else begin
         check("os_sel_o",   bus_if.os_sel_o,   m_os);
         check("cfg_ack",    bus_if.cfg_ack,    m_ack);
         check("cic_clr",    bus_if.cic_clr,    m_cclr);
         check("dec_strobe", bus_if.dec_strobe, m_strobe);
         check("out_valid",  bus_if.out_valid,  m_valid);
         check("busy",       bus_if.busy,       m_busy);
`ifdef CIC_RATE_CTRL_STAT_EN
         check("stat_samples",  bus_if.stat_samples,  m_samples);
         check("stat_reconfig", bus_if.stat_reconfig, m_reconf);
`else
         check("stat_samples",  bus_if.stat_samples,  0);
         check("stat_reconfig", bus_if.stat_reconfig, 0);
`endif
         if (bus_if.cic_clr && !prev_clr) clr_rises++;
         prev_clr = bus_if.cic_clr;
         if (bus_if.cic_clr) clr_run++;
         else if (clr_run != 0) begin
            clr_len = clr_run; clr_run = 0; masked = 0; seen_valid = 0;
         end
         if (bus_if.dec_strobe) begin
            period_meas = cyc - last_strobe;
            last_strobe = cyc;
            if (!seen_valid) begin
               if (bus_if.out_valid) begin seen_valid = 1; masked_meas = masked; end
               else masked++;
            end
         end
         if (bus_if.out_valid) valid_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ack();
      bit got = 0;
      for (int i = 0; i < 600 && !got; i++) begin
         @(negedge clk);
         if (bus_if.cfg_ack) got = 1;
      end
      if (!got) check("ack_timeout", 0, 1);
      bus_if.cfg_req = 1'b0;
   endtask

   task automatic request(input int os);
      bus_if.cfg_req    = 1'b1;
      bus_if.cfg_os_sel = 3'(os);
      wait_ack();
   endtask

   task automatic check_outputs_reset();
      check("rst_os",      bus_if.os_sel_o,      DEF_OS);
      check("rst_strobe",  bus_if.dec_strobe,    0);
      check("rst_valid",   bus_if.out_valid,     0);
      check("rst_clr",     bus_if.cic_clr,       0);
      check("rst_ack",     bus_if.cfg_ack,       0);
      check("rst_busy",    bus_if.busy,          0);
      check("rst_samples", bus_if.stat_samples,  0);
      check("rst_reconf",  bus_if.stat_reconfig, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int before_rises, before_reconf;
      bit settle_ok;

      reset_n = 1'b1;
      bus_if.enable = 1'b0; bus_if.cfg_req = 1'b0; bus_if.cfg_os_sel = 3'd0;
      #1 reset_n = 1'b0;
      run(3);
      check_outputs_reset();
      reset_n = 1'b1;

      // 1: start-up at default os
      bus_if.enable = 1'b1;
      run(40);
      check("t1_clr_len", clr_len, 4);
      check("t1_masked", masked_meas, 4);
      check("t1_period", period_meas, 2);
      check("t1_os", bus_if.os_sel_o, 1);

      // 2: change to os=3 at the boundary
      request(3);
      run(100);
      check("t2_os", bus_if.os_sel_o, 3);
      check("t2_clr_len", clr_len, 4);
      check("t2_masked", masked_meas, 4);
      check("t2_period", period_meas, 8);

      // 3: os=0, strobe every cycle
      request(0);
      run(30);
      check("t3_period", period_meas, 1);
      check("t3_masked", masked_meas, 4);
      check("t3_valid", bus_if.out_valid, 1);

      // 4: same os requested -> no disturbance
      before_rises  = clr_rises;
      before_reconf = int'(bus_if.stat_reconfig);
      request(0);
      run(10);
      check("t4_no_clr", clr_rises, before_rises);
      check("t4_period", period_meas, 1);
      check("t4_reconf", bus_if.stat_reconfig, before_reconf);

      // 5: enable dropped during SETTLE
      request(2);
      settle_ok = 0;
      for (int i = 0; i < 50 && !settle_ok; i++) begin
         @(negedge clk);
         if (!bus_if.cic_clr) settle_ok = 1;
      end
      check("t5_clr_end", settle_ok, 1);
      run(3);
      check("t5_busy_settle", bus_if.busy, 1);
      bus_if.enable = 1'b0;
      run(1);
      check("t5_strobe_off", bus_if.dec_strobe, 0);
      check("t5_valid_off", bus_if.out_valid, 0);
      check("t5_busy_off", bus_if.busy, 0);
      run(3);
      bus_if.enable = 1'b1;
      run(60);
      check("t5_clr_len", clr_len, 4);
      check("t5_masked", masked_meas, 4);
      check("t5_period", period_meas, 4);

      // 6: clamp 7 -> MAX_OS=5
      before_reconf = int'(bus_if.stat_reconfig);
      request(7);
      run(300);
      check("t6_os_clamp", bus_if.os_sel_o, MAX_OS);
      check("t6_period", period_meas, 32);
      #1;
`ifdef CIC_RATE_CTRL_STAT_EN
      check("t6_reconf_inc", bus_if.stat_reconfig, before_reconf + 1);
      check("t6_samples", bus_if.stat_samples, valid_cnt);
`else
      check("t6_reconf_off", bus_if.stat_reconfig, 0);
      check("t6_samples_off", bus_if.stat_samples, 0);
`endif

      // 7: asynchronous reset mid-operation
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_outputs_reset();
      // 8: enable and request together straight out of reset
      bus_if.cfg_req = 1'b1; bus_if.cfg_os_sel = 3'd4;
      @(negedge clk);
      reset_n = 1'b1;
      wait_ack();
      run(120);
      check("t8_os", bus_if.os_sel_o, 4);
      check("t8_clr_len", clr_len, 4);
      check("t8_period", period_meas, 16);

      // random traffic
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (bus_if.cfg_req && bus_if.cfg_ack) bus_if.cfg_req = 1'b0;
         else if (!bus_if.cfg_req && $urandom_range(0, 15) == 0) begin
            bus_if.cfg_req    = 1'b1;
            bus_if.cfg_os_sel = 3'($urandom_range(0, 7));
         end else if (bus_if.cfg_req && $urandom_range(0, 31) == 0)
            bus_if.cfg_os_sel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 149) == 0) bus_if.enable = ~bus_if.enable;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
